// File: rtl/display_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module   : display_arbiter_pkg
// Brief    : Shared types and constants for the display arbiter.
//            The optional blanking gap between owners is enabled by defining
//            DISPLAY_ARBITER_BLANK_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package display_arbiter_pkg;

    localparam int DATA_W  = 16;   // four hex nibbles per requester
    localparam int POINT_W = 4;    // one decimal point per digit
    localparam int CNT_W   = 24;   // dwell and blank counter width

`ifdef DISPLAY_ARBITER_BLANK_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_BLANK = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1
    } state_t;
`endif

    // Counter decrement that holds at zero instead of wrapping
    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] cnt);
        return (cnt == '0) ? '0 : cnt - CNT_W'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/display_arbiter_rr_picker.sv
//------------------------------------------------------------------------------
// Module   : rr_picker
// Brief    : Combinational round-robin search. Scans requesters starting at
//            lastOwner+1, wrapping modulo NUM_REQ, and returns the first
//            active one as a one-hot pick.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   lastOwner,
    output logic [NUM_REQ-1:0] pick,
    output logic               anyValid
);

    logic found;
    int   idx;

    // First active requester after lastOwner, in rotating order
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(lastOwner) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign anyValid = |req;

endmodule

`default_nettype wire

// File: rtl/display_arbiter.sv
//------------------------------------------------------------------------------
// Module   : display_arbiter
// Brief    : Round-robin arbiter sharing one 4-digit seven-segment display
//            between NUM_REQ requesters, with a minimum dwell per owner.
//            Define DISPLAY_ARBITER_BLANK_EN to insert a BLANK_CYCLES gap
//            (grant 0, blank 1) between owners.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module display_arbiter
    import display_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DWELL_CYCLES = 1048576,
    parameter int BLANK_CYCLES = 65536
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [DATA_W*NUM_REQ-1:0]  reqData,
    input  logic [POINT_W*NUM_REQ-1:0] reqPoint,
    output logic [NUM_REQ-1:0]         grant,
    output logic [DATA_W-1:0]          data,
    output logic [POINT_W-1:0]         pointEnable,
    output logic                       valid,
    output logic                       blank
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] DWELL_RELOAD = CNT_W'(DWELL_CYCLES - 1);

    // Elaboration-time range checks on the configuration
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("display_arbiter: NUM_REQ out of range 2..8");
    end
    if (DWELL_CYCLES < 1 || DWELL_CYCLES > (1 << CNT_W)) begin : g_bad_dwell
        $error("display_arbiter: DWELL_CYCLES out of range");
    end
    if (BLANK_CYCLES < 1 || BLANK_CYCLES > (1 << CNT_W)) begin : g_bad_blank
        $error("display_arbiter: BLANK_CYCLES out of range");
    end

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [CNT_W-1:0]     dwell_q, dwell_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [POINT_W-1:0]   point_q, point_d;
    logic                 valid_q;

    logic [NUM_REQ-1:0]   pick;
    logic                 pick_any;
    logic [IDX_W-1:0]     pick_idx;
    logic                 owner_req;
    logic                 others_req;
    logic                 release_own;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .req       (req),
        .lastOwner (last_q),
        .pick      (pick),
        .anyValid  (pick_any)
    );

    // Encode the one-hot pick so lastOwner can be stored compactly
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                pick_idx = IDX_W'(i);
            end
        end
    end

    // Owner gives up the display when it drops req, or when its dwell has
    // expired and someone else is waiting
    assign owner_req   = |(req & grant_q);
    assign others_req  = |(req & ~grant_q);
    assign release_own = !owner_req || ((dwell_q == '0) && others_req);

`ifdef DISPLAY_ARBITER_BLANK_EN
    localparam logic [CNT_W-1:0] BLANK_RELOAD = CNT_W'(BLANK_CYCLES - 1);

    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic             blank_q;

    // Next-state and grant logic, with blanking gap between owners
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        dwell_d = sat_dec(dwell_q);
        bcnt_d  = sat_dec(bcnt_q);
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_OWN;
                    grant_d = pick;
                    last_d  = pick_idx;
                    dwell_d = DWELL_RELOAD;
                end
            end
            ST_OWN: begin
                if (release_own) begin
                    state_d = ST_BLANK;
                    grant_d = '0;
                    bcnt_d  = BLANK_RELOAD;
                end
            end
            ST_BLANK: begin
                if (bcnt_q == '0) begin
                    if (pick_any) begin
                        state_d = ST_OWN;
                        grant_d = pick;
                        last_d  = pick_idx;
                        dwell_d = DWELL_RELOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Blank counter and registered blank flag
    always_ff @(posedge clock) begin
        if (reset) begin
            bcnt_q  <= '0;
            blank_q <= 1'b0;
        end else begin
            bcnt_q  <= bcnt_d;
            blank_q <= (state_d == ST_BLANK);
        end
    end

    assign blank = blank_q;
`else
    // Next-state and grant logic, switching owners directly
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        dwell_d = sat_dec(dwell_q);
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_OWN;
                    grant_d = pick;
                    last_d  = pick_idx;
                    dwell_d = DWELL_RELOAD;
                end
            end
            ST_OWN: begin
                if (release_own) begin
                    if (pick_any) begin
                        grant_d = pick;
                        last_d  = pick_idx;
                        dwell_d = DWELL_RELOAD;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign blank = 1'b0;
`endif

    // Display payload follows the current owner one cycle later; it is
    // forced to zero as soon as no one will own the display next cycle
    always_comb begin
        data_d  = '0;
        point_d = '0;
        if (|grant_d) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_q[i]) begin
                    data_d  = reqData[i*DATA_W +: DATA_W];
                    point_d = reqPoint[i*POINT_W +: POINT_W];
                end
            end
        end
    end

    // State, grant, counters and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            dwell_q <= '0;
            data_q  <= '0;
            point_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            dwell_q <= dwell_d;
            data_q  <= data_d;
            point_q <= point_d;
            valid_q <= |grant_d;
        end
    end

    assign grant       = grant_q;
    assign data        = data_q;
    assign pointEnable = point_q;
    assign valid       = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_display_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_display_arbiter
// Brief    : Directed, table-driven bench for display_arbiter with
//            NUM_REQ=4, DWELL_CYCLES=8, BLANK_CYCLES=3.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_display_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [63:0] reqData;
    logic [15:0] reqPoint;
    logic [3:0]  grant;
    logic [15:0] data;
    logic [3:0]  pointEnable;
    logic        valid;
    logic        blank;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] d0;
        logic [3:0]  g;
        logic [15:0] d;
        logic [3:0]  p;
        logic        v;
    } vec_t;

    vec_t tbl[13];

    always #5 clock = ~clock;

    display_arbiter #(
        .NUM_REQ      (4),
        .DWELL_CYCLES (8),
        .BLANK_CYCLES (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .reqData     (reqData),
        .reqPoint    (reqPoint),
        .grant       (grant),
        .data        (data),
        .pointEnable (pointEnable),
        .valid       (valid),
        .blank       (blank)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [3:0] g, input logic [15:0] d,
                           input logic [3:0] p, input logic v, input logic b);
        chk({nm, " grant"}, 32'(grant), 32'(g));
        chk({nm, " data"},  32'(data), 32'(d));
        chk({nm, " point"}, 32'(pointEnable), 32'(p));
        chk({nm, " valid"}, 32'(valid), 32'(v));
        chk({nm, " blank"}, 32'(blank), 32'(b));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0000;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        req      = 4'b0000;
        reqData  = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'h1234};
        reqPoint = {4'h8, 4'h4, 4'h2, 4'h1};
        tick();
        tick();
        chk_all("reset", 4'b0000, 16'h0000, 4'h0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        chk_all("idle", 4'b0000, 16'h0000, 4'h0, 1'b0, 1'b0);

`ifndef DISPLAY_ARBITER_BLANK_EN
        // Grant, dwell of 8, live data tracking, direct switch, release, rotation
        tbl[0]  = '{4'b0001, 16'h1234, 4'b0001, 16'h0000, 4'h0, 1'b1};
        tbl[1]  = '{4'b0101, 16'h1234, 4'b0001, 16'h1234, 4'h1, 1'b1};
        tbl[2]  = '{4'b0101, 16'h1234, 4'b0001, 16'h1234, 4'h1, 1'b1};
        tbl[3]  = '{4'b0101, 16'h1234, 4'b0001, 16'h1234, 4'h1, 1'b1};
        tbl[4]  = '{4'b0101, 16'h1234, 4'b0001, 16'h1234, 4'h1, 1'b1};
        tbl[5]  = '{4'b0101, 16'hABCD, 4'b0001, 16'hABCD, 4'h1, 1'b1};
        tbl[6]  = '{4'b0101, 16'hABCD, 4'b0001, 16'hABCD, 4'h1, 1'b1};
        tbl[7]  = '{4'b0101, 16'hABCD, 4'b0001, 16'hABCD, 4'h1, 1'b1};
        tbl[8]  = '{4'b0101, 16'hABCD, 4'b0100, 16'hABCD, 4'h1, 1'b1};
        tbl[9]  = '{4'b0101, 16'hABCD, 4'b0100, 16'hCCCC, 4'h4, 1'b1};
        tbl[10] = '{4'b0000, 16'hABCD, 4'b0000, 16'h0000, 4'h0, 1'b0};
        tbl[11] = '{4'b0010, 16'hABCD, 4'b0010, 16'h0000, 4'h0, 1'b1};
        tbl[12] = '{4'b0010, 16'hABCD, 4'b0010, 16'hBBBB, 4'h2, 1'b1};
        for (int i = 0; i < 13; i++) begin
            req           = tbl[i].req;
            reqData[15:0] = tbl[i].d0;
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].g, tbl[i].d, tbl[i].p, tbl[i].v, 1'b0);
        end

        // All four requesting: each owner holds exactly 8 cycles, starting at 0
        reqData[15:0] = 16'h1234;
        do_reset();
        req = 4'b1111;
        for (int k = 1; k <= 40; k++) begin
            tick();
            chk($sformatf("rr cycle%0d grant", k), 32'(grant),
                32'(4'b0001 << (((k - 1) / 8) % 4)));
        end

        // Owner 2 drops req mid-dwell while requester 3 waits
        do_reset();
        req = 4'b1100;
        tick();
        chk("own2 grant", 32'(grant), 32'(4'b0100));
        tick();
        tick();
        chk("own2 dwell5 grant", 32'(grant), 32'(4'b0100));
        req = 4'b1000;
        tick();
        chk_all("drop2", 4'b1000, 16'hCCCC, 4'h4, 1'b1, 1'b0);
        tick();
        chk_all("own3", 4'b1000, 16'hDDDD, 4'h8, 1'b1, 1'b0);
`else
        // Release of owner 0 opens a 3-cycle blank gap before requester 1
        do_reset();
        req = 4'b0011;
        tick();
        chk_all("blk grant0", 4'b0001, 16'h0000, 4'h0, 1'b1, 1'b0);
        req = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_all($sformatf("blk gap%0d", k), 4'b0000, 16'h0000, 4'h0, 1'b0, 1'b1);
        end
        tick();
        chk_all("blk grant1", 4'b0010, 16'h0000, 4'h0, 1'b1, 1'b0);
        tick();
        chk_all("blk data1", 4'b0010, 16'hBBBB, 4'h2, 1'b1, 1'b0);
`endif

        // Reset mid-dwell aborts ownership; requester 0 wins again afterwards
        reqData[15:0] = 16'h1234;
        do_reset();
        req = 4'b0011;
        tick();
        chk("pre-rst grant", 32'(grant), 32'(4'b0001));
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk_all("mid-rst", 4'b0000, 16'h0000, 4'h0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        chk_all("post-rst", 4'b0001, 16'h0000, 4'h0, 1'b1, 1'b0);
        tick();
        chk_all("post-rst data", 4'b0001, 16'h1234, 4'h1, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one 4-digit seven-segment display; legal range 2..8.
REQ-002 Parameter DWELL_CYCLES, default 1048576: minimum clock cycles a granted owner keeps the display while others wait; legal 1..2^24.
REQ-003 Parameter BLANK_CYCLES, default 65536: length of the blanking gap between owners; legal 1..2^24; used only when the blanking feature is compiled in.
REQ-004 clock  in  1  single clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req  in  NUM_REQ  per-requester display request, level-sensitive.
REQ-007 reqData  in  16*NUM_REQ  four hex nibbles per requester; requester i occupies bits [16i+15:16i].
REQ-008 reqPoint  in  4*NUM_REQ  decimal-point enables per requester; requester i occupies bits [4i+3:4i].
REQ-009 grant  out  NUM_REQ  one-hot current owner, or all zero.
REQ-010 data  out  16  registered display data for the seven-segment controller.
REQ-011 pointEnable  out  4  registered decimal-point enables.
REQ-012 valid  out  1  high while any requester owns the display.
REQ-013 blank  out  1  high during the blanking gap.

Function
REQ-014 States SHALL be IDLE, OWN and BLANK; BLANK is reachable only with the blanking feature.
REQ-015 IDLE: with any req high, the block SHALL grant the next owner chosen round-robin, set grant one-hot next cycle, enter OWN and load the dwell counter with DWELL_CYCLES-1.
REQ-016 Round-robin search SHALL start at lastOwner+1 and wrap modulo NUM_REQ; lastOwner updates on every grant.
REQ-017 OWN: the dwell counter SHALL decrement each cycle and saturate at 0.
REQ-018 OWN: if the owner drops req, the block SHALL release on the next edge regardless of dwell, switching to the next requester or to IDLE.
REQ-019 OWN: if dwell is 0 and any other req is high, the block SHALL switch owners; otherwise the owner SHALL keep the display indefinitely.
REQ-020 Without blanking, a switch SHALL move grant directly to the new owner in one cycle with no all-zero grant cycle.
REQ-021 data and pointEnable SHALL be the owner's reqData/reqPoint slices registered with 1-cycle latency, tracking live changes; in IDLE and BLANK both SHALL be 0.
REQ-022 valid SHALL equal the OR of grant; grant SHALL never have more than one bit set.
REQ-023 A req asserted and dropped within the same cycle window before sampling SHALL be ignored; no request latching.

Reset
REQ-024 On reset: state IDLE; grant, data, pointEnable, valid and blank all 0; dwell and blank counters 0; lastOwner NUM_REQ-1, so requester 0 wins first.
REQ-025 Reset asserted mid-dwell or mid-blank SHALL abort immediately with no grant on the following cycle.

Configuration
REQ-026 Macro DISPLAY_ARBITER_BLANK_EN defined: on a release or switch, the block SHALL enter BLANK for BLANK_CYCLES cycles with grant 0 and blank 1, then rerun the round-robin search against req sampled on BLANK's final cycle, going to OWN or IDLE.
REQ-027 Macro undefined: no BLANK state or blank counter SHALL exist and blank SHALL be tied 0.

Structure
REQ-028 Package display_arbiter_pkg SHALL hold the state enum, the data width (16) and point width (4) constants, and the dwell/blank counter width (24).
REQ-029 The round-robin search SHALL be a sub-module rr_picker: inputs req and lastOwner; outputs one-hot pick and any-valid; purely combinational.

Verification (NUM_REQ=4, DWELL_CYCLES=8, BLANK_CYCLES=3)
REQ-030 Reset, then req=0001 with reqData0=0x1234 -> grant=0001 one cycle later; data=0x1234 one cycle after that; valid=1.
REQ-031 Owner 0 held and req=0101 from the grant cycle -> grant stays 0001 for 8 cycles, then moves to 0100 with no zero-grant cycle (macro off).
REQ-032 req=1111 held for 40 cycles -> grant sequence 0001, 0010, 0100, 1000, 0001, each held 8 cycles.
REQ-033 Owner 2 drops req at dwell count 5 while req3=1 -> grant=1000 on the next edge.
REQ-034 Macro on, owner 0 releases while req1=1 -> 3 cycles with grant=0000, blank=1 and data=0, then grant=0010.
REQ-035 Assert reset for one cycle mid-dwell with req=0011 -> next cycle all outputs 0; after release, grant=0001.
